// File: rtl/pwm_capture_if.sv
// PWM capture bus: enable and raw line in, published measurement out.
interface pwm_capture_if #(
  parameter int CNT_W = 10
);
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W:0]   period;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output en, pwm_in,
    input  duty, period, valid, stuck, stuck_level
  );

  modport slave (
    input  en, pwm_in,
    output duty, period, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM decoder: synchronizes the line, measures high/low phase lengths in clk
// cycles and publishes duty/period per period, or a stuck report on timeout.
module pwm_capture #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_STUCK = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             sl_q, sl_d;

  logic rise, fall, any_edge, at_lim, tmo;

  assign rise     = s2_q & ~prev_q;
  assign fall     = ~s2_q & prev_q;
  assign any_edge = rise | fall;

  // Phase counter that governs the timeout in the current state.
  always_comb begin
    at_lim = 1'b0;
    case (state_q)
      S_IDLE, S_ARM: at_lim = (run_q == TMO);
      S_HIGH:        at_lim = (high_q == TMO);
      S_LOW:         at_lim = (low_q == TMO);
      default:       at_lim = 1'b0;
    endcase
  end

  // An edge in the same cycle always beats the timeout.
  assign tmo = ~any_edge & at_lim &
               (((state_q == S_IDLE) & s2_q) | (state_q == S_ARM) |
                (state_q == S_HIGH) | (state_q == S_LOW));

  // Synchronizer stage inputs
  always_comb begin
    s1_d   = bus.pwm_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      run_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      sl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      high_q   <= high_d;
      low_q    <= low_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      sl_q     <= sl_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tmo)        state_d = S_STUCK;
          else if (!s2_q) state_d = S_ARM;
        end
        S_ARM: begin
          if (rise)      state_d = S_HIGH;
          else if (tmo)  state_d = S_STUCK;
        end
        S_HIGH: begin
          if (fall)      state_d = S_LOW;
          else if (tmo)  state_d = S_STUCK;
        end
        S_LOW: begin
          if (rise)      state_d = S_HIGH;
          else if (tmo)  state_d = S_STUCK;
        end
        S_STUCK: begin
          if (rise)      state_d = S_HIGH;
          else if (fall) state_d = S_ARM;
        end
        default:         state_d = S_IDLE;
      endcase
    end
  end

  // Counters and published outputs
  always_comb begin
    run_d    = run_q;
    high_d   = high_q;
    low_d    = low_q;
    duty_d   = duty_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    sl_d     = sl_q;
    valid_d  = 1'b0;
    if (!bus.en) begin
      run_d   = '0;
      high_d  = '0;
      low_d   = '0;
      stuck_d = 1'b0;
    end else if (tmo) begin
      duty_d   = '0;
      period_d = '0;
      stuck_d  = 1'b1;
      valid_d  = 1'b1;
      sl_d     = (state_q == S_IDLE) || (state_q == S_HIGH);
    end else begin
      case (state_q)
        S_IDLE, S_ARM: begin
          if ((state_q == S_ARM) && rise) begin
            high_d = ONE;
            low_d  = '0;
          end else begin
            run_d = any_edge ? ONE : run_q + ONE;
          end
        end
        S_HIGH: begin
          if (fall) low_d  = ONE;
          else      high_d = high_q + ONE;
        end
        S_LOW: begin
          if (rise) begin
            duty_d   = high_q;
            period_d = {1'b0, high_q} + {1'b0, low_q};
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            high_d   = ONE;
            low_d    = '0;
          end else begin
            low_d = low_q + ONE;
          end
        end
        S_STUCK: begin
          // Re-entering HIGH from a stuck line skips the partial period.
          if (rise) begin
            high_d = ONE;
            low_d  = '0;
          end else if (fall) begin
            run_d = ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.duty        = duty_q;
  assign bus.period      = period_q;
  assign bus.valid       = valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = sl_q;

endmodule
